regfile_port_sched: RTL and testbench

- Sequencer and arbiter for the single-port LC-3 register file, which has one shared select for read and write: `write_en`, `in`, `sel`, `out`.
- Serialises two requesters onto that port:
  - a decode-side operand-read request needing up to two source registers (SR1, SR2);
  - a writeback request carrying one destination write (DR).
- Captures the read values into holding registers and returns them as one atomic response.
- Sits between decode/execute/writeback and the regfile instance. The regfile is instantiated outside this block.

---
 rtl/lc3_pkg.sv | 21 ++
 rtl/regfile_port_sched_if.sv | 50 +++++
 rtl/regfile_port_sched_wb_streak_cnt.sv | 36 +++
 rtl/regfile_port_sched.sv | 123 ++++++++++++
 tb/tb_regfile_port_sched.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 register-file constants and the port scheduler state type.
package lc3_pkg;

  localparam int REG_SEL_W = 3;
  localparam int WORD_W    = 16;

  typedef enum logic [1:0] {
    IDLE,
    RD1,
    RD2,
    RESP
  } rf_sched_state_t;

  // First state after an accepted request: skip read slots whose operand is unused.
  function automatic rf_sched_state_t first_read_state(input logic use_sr1, input logic use_sr2);
    if (use_sr1) return RD1;
    if (use_sr2) return RD2;
    return RESP;
  endfunction

endpackage

// File: rtl/regfile_port_sched_if.sv
// Operand request/response, writeback and regfile-port bundle for regfile_port_sched.
interface regfile_port_sched_if #(
  parameter int WIDTH = lc3_pkg::WORD_W,
  parameter int SEL_W = lc3_pkg::REG_SEL_W
);
  logic             req_valid;
  logic             req_ready;
  logic [SEL_W-1:0] req_sr1;
  logic [SEL_W-1:0] req_sr2;
  logic             req_use_sr1;
  logic             req_use_sr2;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_sr1_val;
  logic [WIDTH-1:0] rsp_sr2_val;

  logic             wb_valid;
  logic             wb_ready;
  logic [SEL_W-1:0] wb_dr;
  logic [WIDTH-1:0] wb_data;

  logic             rf_write_en;
  logic [WIDTH-1:0] rf_in;
  logic [SEL_W-1:0] rf_sel;
  logic [WIDTH-1:0] rf_out;

  modport slave (
    input  req_valid, req_sr1, req_sr2, req_use_sr1, req_use_sr2,
    output req_ready,
    output rsp_valid, rsp_sr1_val, rsp_sr2_val,
    input  rsp_ready,
    input  wb_valid, wb_dr, wb_data,
    output wb_ready,
    output rf_write_en, rf_in, rf_sel,
    input  rf_out
  );

  modport master (
    output req_valid, req_sr1, req_sr2, req_use_sr1, req_use_sr2,
    input  req_ready,
    input  rsp_valid, rsp_sr1_val, rsp_sr2_val,
    output rsp_ready,
    output wb_valid, wb_dr, wb_data,
    input  wb_ready,
    input  rf_write_en, rf_in, rf_sel,
    output rf_out
  );

endinterface

// File: rtl/regfile_port_sched_wb_streak_cnt.sv
// Saturating count of back-to-back writeback grants that starved a waiting read.
// Registered count, combinational at-limit flag; clear wins over increment.
module wb_streak_cnt #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_limit_o
);

  localparam int CW = $clog2(MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_limit_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == CW'(MAX));

endmodule

// File: rtl/regfile_port_sched.sv
// Arbitrates one shared regfile select between operand reads and writebacks.
// Response 1-3 cycles after accept (one per used operand); response held until rsp_ready.
module regfile_port_sched
  import lc3_pkg::*;
#(
  parameter int WIDTH         = WORD_W,
  parameter int SEL_W         = REG_SEL_W,
  parameter int MAX_WB_STREAK = 4
) (
  input logic                 clk,
  input logic                 rst,
  regfile_port_sched_if.slave bus
);

  rf_sched_state_t  state_q, state_d;
  logic [SEL_W-1:0] sr1_q, sr2_q;
  logic             use_sr2_q;
  logic [WIDTH-1:0] sr1_val_q, sr2_val_q;

  logic wb_grant;
  logic req_accept;
  logic streak_inc;
  logic streak_clr;
  logic at_limit;

  wb_streak_cnt #(
    .MAX(MAX_WB_STREAK)
  ) u_streak (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (streak_clr),
    .inc_i     (streak_inc),
    .at_limit_o(at_limit)
  );

  always_comb begin
    state_d       = state_q;
    wb_grant      = 1'b0;
    req_accept    = 1'b0;
    streak_inc    = 1'b0;
    streak_clr    = 1'b0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rf_sel    = '0;

    case (state_q)
      IDLE: begin
        // Writeback wins unless it has already starved a waiting read too long.
        wb_grant      = bus.wb_valid && !(bus.req_valid && at_limit);
        bus.req_ready = !wb_grant;
        req_accept    = bus.req_valid && !wb_grant;
        streak_inc    = wb_grant && bus.req_valid;
        streak_clr    = req_accept || !bus.req_valid;
        if (req_accept) begin
          state_d = first_read_state(bus.req_use_sr1, bus.req_use_sr2);
        end
      end
      RD1: begin
        bus.rf_sel = sr1_q;
        state_d    = first_read_state(1'b0, use_sr2_q);
      end
      RD2: begin
        bus.rf_sel = sr2_q;
        state_d    = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        wb_grant      = bus.wb_valid;
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (wb_grant) begin
      bus.rf_sel = bus.wb_dr;
    end

    if (rst) begin
      state_d       = IDLE;
      wb_grant      = 1'b0;
      req_accept    = 1'b0;
      streak_inc    = 1'b0;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.rf_sel    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sr1_q     <= '0;
      sr2_q     <= '0;
      use_sr2_q <= 1'b0;
      sr1_val_q <= '0;
      sr2_val_q <= '0;
    end else begin
      state_q <= state_d;
      if (req_accept) begin
        sr1_q     <= bus.req_sr1;
        sr2_q     <= bus.req_sr2;
        use_sr2_q <= bus.req_use_sr2;
        sr1_val_q <= '0;
        sr2_val_q <= '0;
      end
      if (state_q == RD1) begin
        sr1_val_q <= bus.rf_out;
      end
      if (state_q == RD2) begin
        sr2_val_q <= bus.rf_out;
      end
    end
  end

  assign bus.wb_ready    = wb_grant;
  assign bus.rf_write_en = wb_grant;
  assign bus.rf_in       = bus.wb_data;
  assign bus.rsp_sr1_val = sr1_val_q;
  assign bus.rsp_sr2_val = sr2_val_q;

endmodule

// File: tb/tb_regfile_port_sched.sv
// Bench for regfile_port_sched: directed vectors, corner sequences and a random run with a transaction model.
module tb_regfile_port_sched;
  import lc3_pkg::*;

  localparam int W    = WORD_W;
  localparam int SW   = REG_SEL_W;
  localparam int MAXS = 2;

  typedef struct {
    logic          u1;
    logic          u2;
    logic [SW-1:0] s1;
    logic [SW-1:0] s2;
    int            lat;
    logic [W-1:0]  v1;
    logic [W-1:0]  v2;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] rf_mem [8] = '{default: '0};

  always #5 clk = ~clk;

  regfile_port_sched_if #(.WIDTH(W), .SEL_W(SW)) bus ();

  regfile_port_sched #(
    .WIDTH(W), .SEL_W(SW), .MAX_WB_STREAK(MAXS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // External single-port regfile: combinational read, write at posedge.
  assign bus.rf_out = rf_mem[bus.rf_sel];
  always @(posedge clk) if (bus.rf_write_en) rf_mem[bus.rf_sel] <= bus.rf_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: register contents from observed grants, expected
  // operands snapshotted at accept, latency from operand count, streak arbitration.
  task automatic monitor();
    logic [W-1:0] ref_rf [8] = '{default: '0};
    logic         busy   = 1'b0;
    logic         seen   = 1'b0;
    int           age    = 0;
    int           elat   = 0;
    int           streak = 0;
    logic [W-1:0] e1     = '0;
    logic [W-1:0] e2     = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy   = 1'b0;
        streak = 0;
      end else if (!busy) begin
        if (bus.wb_valid && (!bus.req_valid || streak < MAXS)) begin
          chk("idle_wb_grant", bus.wb_ready, 1);
          chk("idle_req_blocked", bus.req_ready, 0);
        end else begin
          chk("idle_wb_held", bus.wb_ready, 0);
          chk("idle_req_ready", bus.req_ready, 1);
        end
        chk("idle_rsp_valid", bus.rsp_valid, 0);
        if (bus.wb_valid && bus.wb_ready && bus.req_valid) streak++;
        if (!bus.req_valid) streak = 0;
        if (bus.req_valid && bus.req_ready) begin
          busy   = 1'b1;
          seen   = 1'b0;
          age    = 0;
          streak = 0;
          e1     = bus.req_use_sr1 ? ref_rf[bus.req_sr1] : '0;
          e2     = bus.req_use_sr2 ? ref_rf[bus.req_sr2] : '0;
          elat   = 1 + int'(bus.req_use_sr1) + int'(bus.req_use_sr2);
        end
      end else begin
        age++;
        chk("busy_req_ready", bus.req_ready, 0);
        if (!seen) begin
          chk("rsp_latency", bus.rsp_valid, age == elat);
          if (age >= elat) seen = 1'b1;
        end else begin
          chk("rsp_hold", bus.rsp_valid, 1);
        end
        if (!bus.rsp_valid) begin
          chk("read_wb_blocked", bus.wb_ready, 0);
          chk("read_no_write", bus.rf_write_en, 0);
          if (seen) busy = 1'b0;
        end else begin
          chk("rsp_sr1", bus.rsp_sr1_val, e1);
          chk("rsp_sr2", bus.rsp_sr2_val, e2);
          chk("resp_wb_grant", bus.wb_ready, bus.wb_valid);
          if (bus.rsp_ready && seen) busy = 1'b0;
        end
      end
      if (!rst && bus.wb_valid && bus.wb_ready) ref_rf[bus.wb_dr] = bus.wb_data;
    end
  endtask

  task automatic do_wb(input logic [SW-1:0] dr, input logic [W-1:0] d);
    int n = 0;
    bus.wb_valid = 1'b1;
    bus.wb_dr    = dr;
    bus.wb_data  = d;
    @(negedge clk);
    while (!bus.wb_ready && n < 20) begin
      @(posedge clk); #1; @(negedge clk); n++;
    end
    chk("wb_ready", bus.wb_ready, 1);
    chk("wb_write_en", bus.rf_write_en, 1);
    @(posedge clk); #1;
    bus.wb_valid = 1'b0;
  endtask

  task automatic do_req(input string tag, input logic u1, input logic u2,
                        input logic [SW-1:0] s1, input logic [SW-1:0] s2,
                        input int elat, input logic [W-1:0] e1, input logic [W-1:0] e2);
    int   n   = 0;
    int   lat = 0;
    logic we  = 1'b0;
    bus.req_valid   = 1'b1;
    bus.req_use_sr1 = u1;
    bus.req_use_sr2 = u2;
    bus.req_sr1     = s1;
    bus.req_sr2     = s2;
    @(negedge clk);
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1; @(negedge clk); n++;
    end
    chk({tag, "_accept"}, bus.req_ready, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    lat = 1;
    we  = bus.rf_write_en;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk); #1; @(negedge clk); lat++;
      we = we | bus.rf_write_en;
    end
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_sr1"}, bus.rsp_sr1_val, e1);
    chk({tag, "_sr2"}, bus.rsp_sr2_val, e2);
    chk({tag, "_no_we"}, we, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t tv [7];
    int   ew [7] = '{1, 1, 0, 0, 0, 1, 1};
    int   er [7] = '{0, 0, 1, 0, 0, 0, 0};
    int   ev [7] = '{0, 0, 0, 0, 0, 1, 0};
    int   n;
    logic racc, wacc;

    tv[0] = '{1'b0, 1'b1, 3'd5, 3'd3, 2, 16'h0000, 16'hBEEF};
    tv[1] = '{1'b1, 1'b0, 3'd7, 3'd2, 2, 16'h7777, 16'h0000};
    tv[2] = '{1'b1, 1'b1, 3'd1, 3'd2, 3, 16'h1111, 16'h2222};
    tv[3] = '{1'b1, 1'b1, 3'd6, 3'd6, 3, 16'h6666, 16'h6666};
    tv[4] = '{1'b0, 1'b0, 3'd4, 3'd5, 1, 16'h0000, 16'h0000};
    tv[5] = '{1'b1, 1'b1, 3'd0, 3'd7, 3, 16'h0000, 16'h7777};
    tv[6] = '{1'b1, 1'b1, 3'd4, 3'd3, 3, 16'h4444, 16'hBEEF};

    fork
      monitor();
    join_none

    // Reset with both requesters active: nothing may be granted.
    rst = 1'b1;
    bus.req_valid = 1'b1; bus.req_use_sr1 = 1'b1; bus.req_use_sr2 = 1'b1;
    bus.req_sr1 = '0; bus.req_sr2 = '0;
    bus.wb_valid = 1'b1; bus.wb_dr = 3'd2; bus.wb_data = 16'hDEAD;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_wb_ready", bus.wb_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_write_en", bus.rf_write_en, 0);
    chk("rst_sr1_val", bus.rsp_sr1_val, 0);
    chk("rst_sr2_val", bus.rsp_sr2_val, 0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.wb_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", bus.req_ready, 1);
    @(posedge clk); #1;

    // Grant then read back.
    do_wb(3'd3, 16'hBEEF);
    do_req("t1", 1'b1, 1'b1, 3'd3, 3'd0, 3, 16'hBEEF, 16'h0000);

    for (int i = 1; i < 8; i++) if (i != 3) do_wb(SW'(i), {4{4'(i)}});
    foreach (tv[i]) do_req($sformatf("tv%0d", i), tv[i].u1, tv[i].u2, tv[i].s1, tv[i].s2,
                           tv[i].lat, tv[i].v1, tv[i].v2);

    // Both requesters held: two wb grants, read served, wb granted again in RESP.
    bus.req_valid = 1'b1; bus.req_use_sr1 = 1'b1; bus.req_use_sr2 = 1'b1;
    bus.req_sr1 = 3'd4; bus.req_sr2 = 3'd6;
    bus.wb_valid = 1'b1; bus.wb_dr = 3'd5; bus.wb_data = 16'h5555;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk($sformatf("streak_wb_c%0d", c), bus.wb_ready, ew[c]);
      chk($sformatf("streak_req_c%0d", c), bus.req_ready, er[c]);
      chk($sformatf("streak_rsp_c%0d", c), bus.rsp_valid, ev[c]);
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0; bus.wb_valid = 1'b0;
    @(posedge clk); #1;

    // Response backpressure with a writeback granted during RESP.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_sr1 = 3'd1; bus.req_sr2 = 3'd2;
    bus.req_use_sr1 = 1'b1; bus.req_use_sr2 = 1'b1;
    @(negedge clk);
    chk("bp_accept", bus.req_ready, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 10) begin
      @(posedge clk); #1; @(negedge clk); n++;
    end
    chk("bp_rsp_valid", bus.rsp_valid, 1);
    @(posedge clk); #1;
    bus.wb_valid = 1'b1; bus.wb_dr = 3'd1; bus.wb_data = 16'hCAFE;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) chk("bp_wb_grant", bus.wb_ready, 1);
      chk("bp_hold_valid", bus.rsp_valid, 1);
      chk("bp_hold_sr1", bus.rsp_sr1_val, 16'h1111);
      chk("bp_hold_sr2", bus.rsp_sr2_val, 16'h2222);
      @(posedge clk); #1;
      bus.wb_valid = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_still_valid", bus.rsp_valid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_released", bus.rsp_valid, 0);
    @(posedge clk); #1;
    do_req("bp_readback", 1'b1, 1'b0, 3'd1, 3'd0, 2, 16'hCAFE, 16'h0000);

    // Reset while in RD2 abandons the request.
    bus.req_valid = 1'b1; bus.req_sr1 = 3'd4; bus.req_sr2 = 3'd5;
    bus.req_use_sr1 = 1'b1; bus.req_use_sr2 = 1'b1;
    @(negedge clk);
    chk("rr_accept", bus.req_ready, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rr_req_ready_in_rst", bus.req_ready, 0);
    chk("rr_rsp_in_rst", bus.rsp_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rr_rsp_after", bus.rsp_valid, 0);
    chk("rr_req_ready_held", bus.req_ready, 0);
    chk("rr_sr1_cleared", bus.rsp_sr1_val, 0);
    chk("rr_sr2_cleared", bus.rsp_sr2_val, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rr_idle_ready", bus.req_ready, 1);
      chk("rr_no_rsp", bus.rsp_valid, 0);
      @(posedge clk); #1;
    end
    do_req("rr_new", 1'b1, 1'b1, 3'd4, 3'd5, 3, 16'h4444, 16'h5555);

    // Random traffic obeying valid/ready, checked by the monitor.
    racc = 1'b0;
    wacc = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (!bus.req_valid || racc) begin
        bus.req_valid   = ($urandom_range(0, 2) != 0);
        bus.req_sr1     = SW'($urandom_range(0, 7));
        bus.req_sr2     = SW'($urandom_range(0, 7));
        bus.req_use_sr1 = 1'($urandom_range(0, 1));
        bus.req_use_sr2 = 1'($urandom_range(0, 1));
      end
      if (!bus.wb_valid || wacc) begin
        bus.wb_valid = ($urandom_range(0, 1) != 0);
        bus.wb_dr    = SW'($urandom_range(0, 7));
        bus.wb_data  = W'($urandom);
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      racc = bus.req_valid && bus.req_ready;
      wacc = bus.wb_valid && bus.wb_ready;
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0; bus.wb_valid = 1'b0; bus.rsp_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
